alu_seq: RTL



---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_seq_muldiv.sv | 88 ++++++++
 rtl/alu_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-codes, FSM state encoding and
// small helpers used by both the top level and the multiply/divide unit.
package alu_pkg;

    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_XOR   = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SLTU  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SLT   = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLL   = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SRL   = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRA   = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_MUL   = 4'b1010;
    localparam logic [CTRL_W-1:0] ALU_MULHU = 4'b1011;
    localparam logic [CTRL_W-1:0] ALU_DIVU  = 4'b1100;
    localparam logic [CTRL_W-1:0] ALU_REMU  = 4'b1101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widest datapath the illegal-op pattern generator covers.
    localparam int ILLEGAL_MAX = 128;

    function automatic logic [ILLEGAL_MAX-1:0] illegal_pattern();
        return {(ILLEGAL_MAX/2){2'b01}};
    endfunction

    function automatic logic is_iterative(input logic [CTRL_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) ||
               (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per
// cycle for WIDTH cycles; done pulses in the cycle of the final step.
module alu_seq_muldiv #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CTRL_W-1:0] op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              done,
    output logic [WIDTH-1:0]  result
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic               running;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH:0]     psum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;

    // Multiplier: acc = {partial product, remaining multiplier bits}.
    assign psum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign acc_nx = {psum, acc[WIDTH-1:1]};

    // Divider: trial-subtract the divisor from the shifted partial remainder.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opb};
    assign rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx  = {quo[WIDTH-2:0], ~diff[WIDTH]};

    assign done = running && (cnt == CNT_W'(WIDTH - 1));

    // The result reflects the step being taken this cycle, so the top level
    // can register it on the same edge that finishes the iteration.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        result = acc_nx[WIDTH-1:0];
        case (op)
            ALU_MULHU: result = acc_nx[2*WIDTH-1:WIDTH];
            ALU_DIVU:  result = quo_nx;
            ALU_REMU:  result = rem_nx;
            default:   result = acc_nx[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            rem     <= '0;
            quo     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, a};
            opb     <= b;
            rem     <= '0;
            quo     <= a;
        end else if (running) begin
            acc <= acc_nx;
            rem <= rem_nx;
            quo <= quo_nx;
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish one edge after accept, multiply and
// divide iterate in alu_seq_muldiv; the result is held until out_ready.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [CTRL_W-1:0] ALUControl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  ALUResult,
    output logic              Z,
    output logic              N,
    output logic              busy
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ILLEGAL_RES = WIDTH'(illegal_pattern());

    logic [1:0]        state;
    logic [CTRL_W-1:0] op_q;

    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  sc_res;
    logic              go_iter;
    logic              md_start;
    logic              md_done;
    logic [WIDTH-1:0]  md_result;
    logic              load_en;
    logic [WIDTH-1:0]  load_val;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    assign shamt    = b_in[SH_W-1:0];
    assign go_iter  = is_iterative(ALUControl) && (b_in != '0);
    assign md_start = in_ready && in_valid && go_iter;

    // Single-cycle datapath, evaluated on the accept cycle from the live inputs.
    // Multiply by zero and divide by zero resolve here without iterating.
    always_comb begin
        sc_res = ILLEGAL_RES;
        case (ALUControl)
            ALU_ADD:   sc_res = a_in + b_in;
            ALU_SUB:   sc_res = a_in + ~b_in + 1'b1;
            ALU_AND:   sc_res = a_in & b_in;
            ALU_XOR:   sc_res = a_in ^ b_in;
            ALU_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, a_in < b_in};
            ALU_SLT:   sc_res = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
            ALU_OR:    sc_res = a_in | b_in;
            ALU_SLL:   sc_res = a_in << shamt;
            ALU_SRL:   sc_res = a_in >> shamt;
            ALU_SRA:   sc_res = $unsigned($signed(a_in) >>> shamt);
            ALU_MUL:   sc_res = '0;
            ALU_MULHU: sc_res = '0;
            ALU_DIVU:  sc_res = '1;
            ALU_REMU:  sc_res = a_in;
            default:   sc_res = ILLEGAL_RES;
        endcase
    end

    always_comb begin
        load_en  = 1'b0;
        load_val = sc_res;
        case (state)
            ST_IDLE: load_en = in_valid && !go_iter;
            ST_CALC: begin
                load_en  = md_done;
                load_val = md_result;
            end
            default: load_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            ALUResult <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
        end else begin
            if (load_en) begin
                ALUResult <= load_val;
                Z         <= (load_val == '0);
                N         <= load_val[WIDTH-1];
            end
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= ALUControl;
                        state <= go_iter ? ST_CALC : ST_DONE;
                    end
                end
                ST_CALC: if (md_done) state <= ST_DONE;
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu_seq_muldiv #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (op_q),
        .a      (a_in),
        .b      (b_in),
        .done   (md_done),
        .result (md_result)
    );

endmodule
